// File: rtl/data_mem_responder.sv
// LSU-facing memory responder: one read and one write per cycle, fixed-latency
// pipelined read return with no backpressure, write-first on a same-word collision.
module data_mem_responder #(
  parameter int ADDR_WORDS = 1024,
  parameter int READ_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic [63:0] mem_raddr,
  output logic        mem_rvalid,
  output logic [63:0] mem_rdata,
  input  logic        mem_wen,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  output logic        mem_err
);
  localparam int AW = $clog2(ADDR_WORDS);

  logic [63:0] mem_q [ADDR_WORDS];

  logic [AW-1:0] ridx, widx;
  logic          rd_inr, wr_inr, rd_mis, wr_mis;
  logic          rd_acc, wr_acc, bypass;
  logic [63:0]   rd_word;

  assign ridx   = mem_raddr[3 +: AW];
  assign widx   = mem_waddr[3 +: AW];
  assign rd_inr = (mem_raddr[63:3+AW] == '0);
  assign wr_inr = (mem_waddr[63:3+AW] == '0);
  assign rd_mis = (mem_raddr[2:0] != 3'd0);
  assign wr_mis = (mem_waddr[2:0] != 3'd0);
  assign rd_acc = mem_ren & ~rst;
  assign wr_acc = mem_wen & ~rst;

  // Write-first: a same-cycle write to the read's word is forwarded, never
  // relying on the RAM's own read-during-write behaviour.
  assign bypass  = wr_acc & wr_inr & (widx == ridx);
  assign rd_word = !rd_inr ? 64'd0 : (bypass ? mem_wdata : mem_q[ridx]);

  // Array is intentionally outside reset.
  always_ff @(posedge clk) begin
    if (wr_acc && wr_inr) mem_q[widx] <= mem_wdata;
  end

  logic [READ_LAT-1:0]       vld_q;
  logic [READ_LAT-1:0][63:0] dat_q;
  logic                      err_q;

  // Data stages only advance behind a valid, so the last stage holds the
  // most recently delivered word while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) dat_q[0] <= rd_word;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
      err_q <= (rd_acc & (~rd_inr | rd_mis)) | (wr_acc & (~wr_inr | wr_mis));
    end
  end

  // A response landing on a reset edge is suppressed as well.
  assign mem_rvalid = vld_q[READ_LAT-1] & ~rst;
  assign mem_rdata  = dat_q[READ_LAT-1];
  assign mem_err    = err_q;

endmodule
